strip_frame_scheduler: RTL

STRIP_FRAME_SCHEDULER -- requirements
Module: strip_frame_scheduler

---
 rtl/strip_frame_scheduler_if.sv | 24 ++
 rtl/strip_frame_scheduler.sv | 108 ++++++++++
 2 files changed

// File: rtl/strip_frame_scheduler_if.sv
// Bus between the strip frame scheduler and its two frame buffers / LED encoder.
interface strip_frame_scheduler_if #(parameter int AW = 4);
    logic [1:0]    req;
    logic [1:0]    grant;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data0;
    logic [23:0]   rd_data1;
    logic [23:0]   pixel_out;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          sending_data;
    logic          frame_done;
    logic          busy;

    modport master (
        input  req, rd_data0, rd_data1, pixel_ready,
        output grant, rd_addr, pixel_out, pixel_valid, sending_data, frame_done, busy
    );

    modport slave (
        output req, rd_data0, rd_data1, pixel_ready,
        input  grant, rd_addr, pixel_out, pixel_valid, sending_data, frame_done, busy
    );
endinterface

// File: rtl/strip_frame_scheduler.sv
// Two-requester round-robin LED strip frame scheduler: streams LENGTH pixels in
// {G,R,B} order from the granted buffer, then holds the line idle for the latch gap.
//   state   | meaning
//   IDLE    | no frame owned; waiting for any req bit
//   FETCH   | rd_addr presented, waiting for the buffer read data
//   PRESENT | pixel_out valid, waiting for pixel_ready
//   LATCH   | line idle for LATCH_CYCLES cycles, then frame_done
module strip_frame_scheduler #(
    parameter int LENGTH       = 10,
    parameter int LATCH_CYCLES = 6000,
    parameter int AW           = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input logic clk,
    input logic reset,
    strip_frame_scheduler_if.master bus
);
    localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(LENGTH - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, LATCH} state_t;

    state_t        state;
    logic          fetch_wait;
    logic          last_grant;
    logic          next_winner;
    logic [CW-1:0] latch_cnt;

    function automatic logic [23:0] to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    // Tie goes to whichever requester was not served last.
    always_comb begin
        next_winner = 1'b0;
        if (bus.req == 2'b10)
            next_winner = 1'b1;
        else if (bus.req == 2'b11)
            next_winner = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            fetch_wait       <= 1'b0;
            last_grant       <= 1'b1;
            latch_cnt        <= '0;
            bus.grant        <= 2'b00;
            bus.rd_addr      <= '0;
            bus.pixel_out    <= '0;
            bus.pixel_valid  <= 1'b0;
            bus.sending_data <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant        <= next_winner ? 2'b10 : 2'b01;
                        last_grant       <= next_winner;
                        bus.rd_addr      <= '0;
                        fetch_wait       <= 1'b1;
                        bus.sending_data <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= FETCH;
                    end
                end
                FETCH: begin
                    // The buffers are synchronous reads: data for rd_addr lands one
                    // cycle after it is presented, so the capture waits that cycle out.
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        bus.pixel_out   <= to_grb(bus.grant[1] ? bus.rd_data1 : bus.rd_data0);
                        bus.pixel_valid <= 1'b1;
                        state           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.pixel_ready) begin
                        bus.pixel_valid <= 1'b0;
                        if (bus.rd_addr == LAST_ADDR) begin
                            bus.sending_data <= 1'b0;
                            latch_cnt        <= LATCH_LOAD;
                            state            <= LATCH;
                        end else begin
                            bus.rd_addr <= bus.rd_addr + AW'(1);
                            fetch_wait  <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == '0) begin
                        bus.frame_done <= 1'b1;
                        bus.grant      <= 2'b00;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
